// File: rtl/tks_chan_rx.sv
// tks_chan_rx: receives four-phase bundled-data transfers from an
// asynchronous producer and queues them in a small circular buffer
// that is drained through a valid/ready interface in the clk domain.
module tks_chan_rx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_r,
  input  logic [WIDTH-1:0]           in_d,
  output logic                       in_a,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ARM, IDLE, HOLD} state_t;

  state_t            state_q;
  state_t            state_d;
  logic              s1;
  logic              s2;
  logic              req_s;
  logic [1:0]        settle;
  logic              settled;
  logic              in_a_q;
  logic              full;
  logic              wr_en;
  logic              pop;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  mem [DEPTH];

  assign req_s = s2;
  // The synchroniser is cleared by reset, so s2 only reflects the real
  // in_r level two edges after release; ARM must not trust it before then,
  // otherwise a request held across reset would look like a fresh one.
  assign settled = (settle == 2'd2);
  assign full    = (cnt == CW'(DEPTH));
  assign pop     = out_valid && out_ready;

  // Two-flop synchroniser for in_r plus a settle counter after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      settle <= 2'd0;
    end else begin
      s1 <= in_r;
      s2 <= s1;
      if (!settled) settle <= settle + 2'd1;
    end
  end

  // FSM state register; in_a is a flop that is high exactly in HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARM;
      in_a_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      in_a_q  <= (state_d == HOLD);
    end
  end

  // Next-state logic: ARM waits for a settled low request, IDLE captures
  // when space exists (pre-edge count), HOLD waits for return-to-zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARM:     if (settled && !req_s) state_d = IDLE;
      IDLE:    if (req_s && !full)    state_d = HOLD;
      HOLD:    if (!req_s)            state_d = IDLE;
      default:                        state_d = ARM;
    endcase
  end

  // Output logic: buffer write strobe, only on the IDLE->HOLD transition.
  always_comb begin
    wr_en = 1'b0;
    if (state_q == IDLE && req_s && !full) wr_en = 1'b1;
  end

  // Buffer pointers and occupancy; write and pop may share an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Buffer storage; in_d is stable while the request is seen high, so it
  // is sampled directly without synchronisation.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_ptr] <= in_d;
  end

  assign in_a      = in_a_q;
  assign count     = cnt;
  assign out_valid = (cnt != '0);
  assign out_data  = mem[rd_ptr];

endmodule

// File: tb/tb_tks_chan_rx.sv
// Self-checking bench for tks_chan_rx: directed scenarios plus a random
// four-phase producer / random consumer against a reference queue.
module tb_tks_chan_rx;

  logic       clk;
  logic       reset;
  logic       in_r;
  logic [7:0] in_d;
  logic       in_a;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [1:0] count;

  int checks;
  int failures;
  int occ;
  logic [7:0] sent [$];

  tks_chan_rx #(.WIDTH(8), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_r(in_r), .in_d(in_d), .in_a(in_a),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then scoreboard pops, protocol and occupancy checks.
  task automatic tick();
    logic       pop_now;
    logic       rst_now;
    logic       a_prev;
    logic       r_now;
    logic [7:0] head;
    logic [7:0] exp;
    pop_now = (out_valid === 1'b1) && out_ready && !reset;
    rst_now = reset;
    a_prev  = in_a;
    r_now   = in_r;
    head    = out_data;
    @(posedge clk);
    #1;
    if (rst_now) begin
      sent.delete();
      occ = 0;
    end else begin
      if (pop_now) begin
        exp = 'x;
        if (sent.size() > 0) exp = sent.pop_front();
        chk("pop_data", head, exp);
        occ--;
      end
      if (in_a === 1'b1 && a_prev === 1'b0) begin
        chk("ack_rise_needs_req", r_now, 1'b1);
        occ++;
      end
      if (in_a === 1'b0 && a_prev === 1'b1)
        chk("ack_fall_needs_noreq", r_now, 1'b0);
    end
    chk("count", count, occ);
    chk("out_valid", out_valid, occ != 0);
  endtask

  task automatic wait_a(input logic lvl, input string tag);
    int n;
    n = 0;
    while (in_a !== lvl && n < 30) begin
      tick();
      n++;
    end
    chk(tag, in_a, lvl);
  endtask

  task automatic handshake(input logic [7:0] d);
    in_d = d;
    in_r = 1'b1;
    sent.push_back(d);
    wait_a(1'b1, "hs_ack_high");
    in_r = 1'b0;
    wait_a(1'b0, "hs_ack_low");
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (occ > 0 && n < 60) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("drain_count", count, 0);
    chk("drain_queue", sent.size(), 0);
  endtask

  initial begin
    int phase;
    int done;
    int budget;
    checks    = 0;
    failures  = 0;
    occ       = 0;
    reset     = 1'b1;
    in_r      = 1'b0;
    in_d      = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_a", in_a, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 1'b0);
    reset = 1'b0;
    repeat (5) tick();

    // Single transfer with exact latency.
    in_d = 8'hA5;
    in_r = 1'b1;
    sent.push_back(8'hA5);
    tick(); chk("lat_e1", in_a, 1'b0);
    tick(); chk("lat_e2", in_a, 1'b0);
    tick(); chk("lat_e3", in_a, 1'b1);
    chk("single_valid", out_valid, 1'b1);
    chk("single_data", out_data, 8'hA5);
    chk("single_count", count, 1);
    in_r = 1'b0;
    tick(); chk("rtz_f1", in_a, 1'b1);
    tick(); chk("rtz_f2", in_a, 1'b1);
    tick(); chk("rtz_f3", in_a, 1'b0);
    drain();

    // Fill: third transfer stalls until a pop frees space.
    handshake(8'h01);
    handshake(8'h02);
    chk("fill_count", count, 2);
    in_d = 8'h03;
    in_r = 1'b1;
    sent.push_back(8'h03);
    repeat (6) tick();
    chk("fill_stall_ack", in_a, 1'b0);
    chk("fill_stall_count", count, 2);
    chk("fill_head", out_data, 8'h01);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fill_after_pop_head", out_data, 8'h02);
    wait_a(1'b1, "fill_third_ack");
    chk("fill_third_count", count, 2);
    in_r = 1'b0;
    wait_a(1'b0, "fill_third_rtz");
    drain();

    // Simultaneous write and pop.
    handshake(8'h11);
    chk("sim_pre_count", count, 1);
    in_d = 8'h22;
    in_r = 1'b1;
    sent.push_back(8'h22);
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("sim_ack", in_a, 1'b1);
    chk("sim_count", count, 1);
    chk("sim_data", out_data, 8'h22);
    in_r = 1'b0;
    wait_a(1'b0, "sim_rtz");
    drain();

    // Wrap: ten transfers with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) handshake(8'(i));
    drain();

    // Reset in HOLD with the request still high.
    in_d = 8'h77;
    in_r = 1'b1;
    sent.push_back(8'h77);
    wait_a(1'b1, "rst_hold_ack");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_hold_in_a", in_a, 1'b0);
    chk("rst_hold_count", count, 0);
    repeat (20) tick();
    chk("rst_nocap_in_a", in_a, 1'b0);
    chk("rst_nocap_count", count, 0);
    in_r = 1'b0;
    repeat (5) tick();
    handshake(8'h5C);
    chk("rst_new_count", count, 1);
    chk("rst_new_data", out_data, 8'h5C);
    drain();

    // Random producer / consumer timing.
    phase  = 0;
    done   = 0;
    budget = 60000;
    while (done < 1000 && budget > 0) begin
      out_ready = ($urandom_range(0, 3) != 0);
      case (phase)
        0: if (in_a === 1'b0 && $urandom_range(0, 2) == 0) begin
             in_d = 8'($urandom);
             in_r = 1'b1;
             sent.push_back(in_d);
             phase = 1;
           end
        1: if (in_a === 1'b1 && $urandom_range(0, 1) == 1) begin
             in_r = 1'b0;
             phase = 2;
           end
        default: if (in_a === 1'b0) begin
             done++;
             phase = 0;
           end
      endcase
      tick();
      budget--;
    end
    chk("rand_transfers", done, 1000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
